// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer
//   Two-road intersection controller. The main road owns the crossing by
//   default. The side road (vehicle sensor) and the pedestrian button request a
//   side cycle. The sequence is MG -> MY -> AR1 -> SG -> SY -> AR2 -> MG, and a
//   tick-driven dwell timer paces every phase.
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous reset, active-high
//   tick       in   timebase enable; dwell timers advance only when tick=1
//   side_req   in   side-road vehicle sensor (level)
//   ped_req    in   pedestrian button (pulse or level)
//   main_light out  [0:2] main-road lamp code (RED=100, GREEN=010, YELLOW=001)
//   side_light out  [0:2] side-road lamp code
//   ped_walk   out  walk signal, high during a served side-green phase
//   ped_ack    out  one-cycle pulse on the first cycle of a served side green
//   phase      out  current state code
module traffic_phase_sequencer #(
  parameter int CNT_W    = 8,
  parameter int T_MAIN_G = 20,
  parameter int T_SIDE_G = 10,
  parameter int T_YEL    = 3,
  parameter int T_ALLRED = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [0:2] main_light,
  output logic [0:2] side_light,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } state_t;

  localparam logic [0:2] RED    = 3'b100;
  localparam logic [0:2] GREEN  = 3'b010;
  localparam logic [0:2] YELLOW = 3'b001;

  // Last counter value of a dwell; a duration of 0 behaves like 1.
  function automatic logic [CNT_W-1:0] last_cnt(input int dur);
    if (dur <= 1) begin
      return {CNT_W{1'b0}};
    end else begin
      return CNT_W'(dur - 1);
    end
  endfunction

  localparam logic [CNT_W-1:0] MAIN_G_LAST = last_cnt(T_MAIN_G);
  localparam logic [CNT_W-1:0] SIDE_G_LAST = last_cnt(T_SIDE_G);
  localparam logic [CNT_W-1:0] YEL_LAST    = last_cnt(T_YEL);
  localparam logic [CNT_W-1:0] ALLRED_LAST = last_cnt(T_ALLRED);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dwell_last;
  logic             done;
  logic             ped_pend;
  logic             ped_walk_q;
  logic             serve_edge;
  logic             serve;
  logic             walk_end;

  // Next-state selection, driven by the dwell timer and the pending requests.
  always_comb begin
    dwell_last = MAIN_G_LAST;
    state_next = state;
    case (state)
      MG:      dwell_last = MAIN_G_LAST;
      MY, SY:  dwell_last = YEL_LAST;
      AR1, AR2: dwell_last = ALLRED_LAST;
      SG:      dwell_last = SIDE_G_LAST;
      default: dwell_last = MAIN_G_LAST;
    endcase
    done = tick && (cnt >= dwell_last);
    case (state)
      MG: begin
        // Main green holds indefinitely until someone asks for the crossing.
        if (done && (side_req || ped_pend || ped_req)) begin
          state_next = MY;
        end else begin
          state_next = MG;
        end
      end
      MY:  state_next = done ? AR1 : MY;
      AR1: state_next = done ? SG  : AR1;
      SG:  state_next = done ? SY  : SG;
      SY:  state_next = done ? AR2 : SY;
      AR2: state_next = done ? MG  : AR2;
      default: state_next = MG;
    endcase
    serve_edge = (state == AR1) && (state_next == SG);
    serve      = serve_edge && (ped_pend || ped_req);
    walk_end   = (state == SG) && (state_next == SY);
  end

  // State, dwell timer and pedestrian handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MG;
      cnt        <= {CNT_W{1'b0}};
      ped_pend   <= 1'b0;
      ped_walk_q <= 1'b0;
      ped_ack    <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        cnt <= {CNT_W{1'b0}};
      end else if (tick && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_ONE;
      end else begin
        cnt <= cnt;
      end
      // The serve edge consumes the request; anything later waits for the next cycle.
      if (serve_edge) begin
        ped_pend <= 1'b0;
      end else if (ped_req) begin
        ped_pend <= 1'b1;
      end else begin
        ped_pend <= ped_pend;
      end
      if (serve) begin
        ped_walk_q <= 1'b1;
      end else if (walk_end) begin
        ped_walk_q <= 1'b0;
      end else begin
        ped_walk_q <= ped_walk_q;
      end
      ped_ack <= serve;
    end
  end

  // Moore lamp decode straight from the state register; unknown codes show all red.
  always_comb begin
    main_light = RED;
    side_light = RED;
    case (state)
      MG: begin
        main_light = GREEN;
        side_light = RED;
      end
      MY: begin
        main_light = YELLOW;
        side_light = RED;
      end
      SG: begin
        main_light = RED;
        side_light = GREEN;
      end
      SY: begin
        main_light = RED;
        side_light = YELLOW;
      end
      default: begin
        main_light = RED;
        side_light = RED;
      end
    endcase
  end

  assign ped_walk = ped_walk_q && (state == SG);
  assign phase    = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer
//   Directed bench for traffic_phase_sequencer. A phase-index model, driven by a
//   table of dwell lengths, predicts the outputs on every cycle. Literal
//   expectations (phase at given edges, dwell lengths in clocks, walk/ack
//   counts) pin the model itself.
module tb_traffic_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [0:2] main_light;
  logic [0:2] side_light;
  logic       ped_walk;
  logic       ped_ack;
  logic [2:0] phase;

  int checks = 0;
  int failures = 0;
  int tick_div = 1;
  int tick_ctr = 0;

  traffic_phase_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .side_req  (side_req),
    .ped_req   (ped_req),
    .main_light(main_light),
    .side_light(side_light),
    .ped_walk  (ped_walk),
    .ped_ack   (ped_ack),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase order 0..5 = MG, MY, AR1, SG, SY, AR2; dwell lengths in ticks.
  int         dur [6]      = '{20, 3, 1, 10, 3, 1};
  logic [2:0] main_tab [6] = '{3'b010, 3'b001, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] side_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b100};

  int   m_ph = 0;
  int   m_ticks = 0;
  logic m_pend = 1'b0;
  logic m_walk = 1'b0;
  logic m_ack = 1'b0;
  logic m_valid = 1'b0;
  logic m_fin;
  logic m_adv;
  logic m_serve;

  // This tick completes the phase's dwell; main green also needs a requester.
  assign m_fin   = tick && (m_ticks + 1 >= dur[m_ph]);
  assign m_adv   = m_fin && (m_ph != 0 || side_req || m_pend || ped_req);
  assign m_serve = m_adv && (m_ph == 2) && (m_pend || ped_req);

  always @(posedge clk) begin
    if (rst) begin
      m_ph    <= 0;
      m_ticks <= 0;
      m_pend  <= 1'b0;
      m_walk  <= 1'b0;
      m_ack   <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      m_ph    <= m_adv ? (m_ph + 1) % 6 : m_ph;
      m_ticks <= m_adv ? 0 : m_ticks + (tick ? 1 : 0);
      m_pend  <= (m_adv && m_ph == 2) ? 1'b0 : (m_pend | ped_req);
      m_ack   <= m_serve;
      m_walk  <= m_serve ? 1'b1 : ((m_adv && m_ph == 3) ? 1'b0 : m_walk);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("phase", int'(phase), m_ph);
      check("main_light", int'(main_light), int'(main_tab[m_ph]));
      check("side_light", int'(side_light), int'(side_tab[m_ph]));
      check("ped_walk", int'(ped_walk), int'(m_walk && m_ph == 3));
      check("ped_ack", int'(ped_ack), int'(m_ack));
      check("lamp_exclusive", int'(main_light != 3'b100 && side_light != 3'b100), 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
    tick_ctr++;
    tick = (tick_ctr % tick_div) == 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    side_req = 1'b0;
    ped_req = 1'b0;
    tick_ctr = 0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_check(input int n, input int code, input string name);
    repeat (n) cyc();
    @(negedge clk);
    check(name, int'(phase), code);
  endtask

  // Length in clocks of the next (or current) visit to a phase code.
  task automatic measure(input int code, input int exp_len, input string name);
    int n = 0;
    int guard = 0;
    while (guard < 600) begin
      if (int'(phase) == code) n++;
      else if (n > 0) break;
      cyc();
      @(negedge clk);
      guard++;
    end
    check(name, n, exp_len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int walk_cnt;
    int ack_cnt;

    // 1: reset then idle with tick every cycle: main green, side red throughout.
    tick_div = 1;
    do_reset();
    @(negedge clk);
    check("t1_reset_phase", int'(phase), 0);
    check("t1_reset_main", int'(main_light), 2);
    check("t1_reset_side", int'(side_light), 4);
    repeat (200) cyc();
    @(negedge clk);
    check("t1_idle_phase", int'(phase), 0);
    check("t1_idle_main", int'(main_light), 2);
    check("t1_idle_walk", int'(ped_walk), 0);

    // 2: side_req held: MG 20, MY 3, AR1 1, SG 10, SY 3, AR2 1.
    do_reset();
    side_req = 1'b1;
    wait_check(19, 0, "t2_mg_edge19");
    wait_check(1, 1, "t2_my_edge20");
    wait_check(3, 2, "t2_ar1_edge23");
    wait_check(1, 3, "t2_sg_edge24");
    wait_check(10, 4, "t2_sy_edge34");
    wait_check(3, 5, "t2_ar2_edge37");
    wait_check(1, 0, "t2_mg_edge38");
    wait_check(20, 1, "t2_repeat_my");

    // 3: single ped_req pulse with side_req=0 forces one full side cycle.
    do_reset();
    repeat (5) cyc();
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    wait_check(13, 0, "t3_mg_edge19");
    wait_check(1, 1, "t3_my_edge20");
    walk_cnt = 0;
    ack_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      @(negedge clk);
      walk_cnt += int'(ped_walk);
      ack_cnt += int'(ped_ack);
    end
    check("t3_walk_cycles", walk_cnt, 10);
    check("t3_ack_cycles", ack_cnt, 1);
    check("t3_back_to_mg", int'(phase), 0);

    // 4: tick every 4th clock: each dwell is 4x its tick count.
    tick_div = 4;
    do_reset();
    side_req = 1'b1;
    measure(3, 40, "t4_sg_len");
    measure(4, 12, "t4_sy_len");
    measure(5, 4, "t4_ar2_len");
    measure(0, 80, "t4_mg_len");
    measure(1, 12, "t4_my_len");
    measure(2, 4, "t4_ar1_len");

    // 5: reset in SY with a pending ped_req: back to MG, request dropped.
    tick_div = 1;
    do_reset();
    side_req = 1'b1;
    wait_check(34, 4, "t5_sy_edge34");
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    side_req = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_phase", int'(phase), 0);
    check("t5_rst_main", int'(main_light), 2);
    check("t5_rst_side", int'(side_light), 4);
    wait_check(40, 0, "t5_no_my");

    // 6: ped_req during SG: no ack in that SG, then a second cycle with ack.
    do_reset();
    side_req = 1'b1;
    wait_check(24, 3, "t6_sg_edge24");
    side_req = 1'b0;
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    ack_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      @(negedge clk);
      ack_cnt += int'(ped_ack);
    end
    check("t6_no_extra_ack", ack_cnt, 0);
    wait_check(20, 0, "t6_mg_edge57");
    wait_check(1, 1, "t6_my_edge58");
    wait_check(4, 3, "t6_sg_edge62");
    check("t6_ack_high", int'(ped_ack), 1);
    check("t6_walk_high", int'(ped_walk), 1);
    cyc();
    @(negedge clk);
    check("t6_ack_pulse_end", int'(ped_ack), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
